// File: rtl/sfu_ctrl_if.sv
// Bus bundle between sfu_ctrl and its OFIFO, SFU and output-memory neighbours.
// master = sequencer side, slave = datapath/environment side.
interface sfu_ctrl_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned addr_bw = 11
);
    logic                     fifo_valid_i;
    logic [col*psum_bw-1:0]   fifo_data_i;
    logic                     fifo_rd_o;
    logic                     sfu_acc_o;
    logic                     sfu_bypass_o;
    logic [col*psum_bw-1:0]   sfu_psum_o;
    logic [col*psum_bw-1:0]   sfu_result_i;
    logic                     mem_wr_o;
    logic [addr_bw-1:0]       mem_addr_o;
    logic [col*psum_bw-1:0]   mem_data_o;

    modport master (
        input  fifo_valid_i, fifo_data_i, sfu_result_i,
        output fifo_rd_o, sfu_acc_o, sfu_bypass_o, sfu_psum_o, mem_wr_o, mem_addr_o, mem_data_o
    );

    modport slave (
        output fifo_valid_i, fifo_data_i, sfu_result_i,
        input  fifo_rd_o, sfu_acc_o, sfu_bypass_o, sfu_psum_o, mem_wr_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/sfu_ctrl.sv
// Sequencer for the SFU accumulate/ReLU stage: OFIFO -> SFU -> output memory.
// Optional stall counter output is enabled by defining SFU_CTRL_STALL_CNT_EN.
module sfu_ctrl #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned cnt_bw  = 8,
    parameter int unsigned addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [cnt_bw-1:0]  cfg_num_psum_i,
    input  logic [addr_bw-1:0] cfg_num_out_i,
    input  logic [addr_bw-1:0] cfg_base_addr_i,
    input  logic               cfg_bypass_i,
    sfu_ctrl_if.master         bus,
`ifdef SFU_CTRL_STALL_CNT_EN
    output logic [15:0]        stall_cnt_o,
`endif
    output logic               busy_o,
    output logic               done_o
);
    typedef enum logic [2:0] {StIdle, StAcc, StDrain, StByp, StDone} state_e;

    localparam int unsigned W = col * psum_bw;

    state_e             state_q, state_d;
    logic [cnt_bw-1:0]  num_psum_q, psum_cnt_q, psum_cnt_d;
    logic [addr_bw-1:0] num_out_q, base_q, out_cnt_q, out_cnt_d;
    logic               latch;
    logic               mem_wr_q, mem_wr_d;
    logic [addr_bw-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0]       mem_data_q, mem_data_d;
    logic               stall;

    assign bus.mem_wr_o   = mem_wr_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;

    always_comb begin
        state_d          = state_q;
        psum_cnt_d       = psum_cnt_q;
        out_cnt_d        = out_cnt_q;
        latch            = 1'b0;
        mem_wr_d         = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_data_d       = mem_data_q;
        stall            = 1'b0;
        bus.fifo_rd_o    = 1'b0;
        bus.sfu_acc_o    = 1'b0;
        bus.sfu_bypass_o = 1'b0;
        bus.sfu_psum_o   = '0;
        busy_o           = 1'b1;
        done_o           = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (start_i) begin
                    latch      = 1'b1;
                    psum_cnt_d = '0;
                    out_cnt_d  = '0;
                    if (cfg_num_out_i == '0) state_d = StDone;
                    else if (cfg_bypass_i)   state_d = StByp;
                    else                     state_d = StAcc;
                end
            end
            StAcc: begin
                bus.fifo_rd_o  = bus.fifo_valid_i;
                // Keep acc high across a mid-group stall so the zero vector is absorbed.
                bus.sfu_acc_o  = (psum_cnt_q != '0) | bus.fifo_valid_i;
                bus.sfu_psum_o = bus.fifo_valid_i ? bus.fifo_data_i : '0;
                stall          = (psum_cnt_q != '0) & ~bus.fifo_valid_i;
                if (bus.fifo_valid_i) begin
                    psum_cnt_d = psum_cnt_q + 1'b1;
                    if (psum_cnt_q == num_psum_q - 1'b1) state_d = StDrain;
                end
            end
            StDrain: begin
                mem_wr_d   = 1'b1;
                mem_data_d = bus.sfu_result_i;
                mem_addr_d = base_q + out_cnt_q;
                out_cnt_d  = out_cnt_q + 1'b1;
                psum_cnt_d = '0;
                state_d    = (out_cnt_q == num_out_q - 1'b1) ? StDone : StAcc;
            end
            StByp: begin
                bus.sfu_bypass_o = 1'b1;
                bus.fifo_rd_o    = bus.fifo_valid_i;
                bus.sfu_psum_o   = bus.fifo_valid_i ? bus.fifo_data_i : '0;
                stall            = ~bus.fifo_valid_i;
                if (bus.fifo_valid_i) begin
                    mem_wr_d   = 1'b1;
                    mem_data_d = bus.sfu_result_i;
                    mem_addr_d = base_q + out_cnt_q;
                    out_cnt_d  = out_cnt_q + 1'b1;
                    if (out_cnt_q == num_out_q - 1'b1) state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            num_psum_q <= '0;
            num_out_q  <= '0;
            base_q     <= '0;
            psum_cnt_q <= '0;
            out_cnt_q  <= '0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            psum_cnt_q <= psum_cnt_d;
            out_cnt_q  <= out_cnt_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            if (latch) begin
                num_psum_q <= (cfg_num_psum_i == '0) ? cnt_bw'(1) : cfg_num_psum_i;
                num_out_q  <= cfg_num_out_i;
                base_q     <= cfg_base_addr_i;
            end
        end
    end

`ifdef SFU_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset)                              stall_cnt_q <= '0;
        else if (latch)                          stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif
endmodule

// File: tb/tb_sfu_ctrl.sv
// Randomised self-checking bench for sfu_ctrl with a lane-level SFU model and a
// job-level reference model (expected writes computed from integer sums).
module tb_sfu_ctrl;
    localparam int unsigned Col = 8, PsumBw = 16, CntBw = 8, AddrBw = 11;
    localparam int unsigned W = Col * PsumBw;
    typedef logic [W-1:0] vec_t;
    typedef struct {logic [AddrBw-1:0] addr; vec_t data;} wr_t;

    logic clk = 1'b0, reset = 1'b0, start_i = 1'b0, cfg_bypass_i = 1'b0;
    logic [CntBw-1:0]  cfg_num_psum_i = '0;
    logic [AddrBw-1:0] cfg_num_out_i = '0, cfg_base_addr_i = '0;
    logic busy_o, done_o;
`ifdef SFU_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    sfu_ctrl_if #(.col(Col), .psum_bw(PsumBw), .addr_bw(AddrBw)) bus ();

    sfu_ctrl #(.col(Col), .psum_bw(PsumBw), .cnt_bw(CntBw), .addr_bw(AddrBw)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .cfg_num_psum_i (cfg_num_psum_i),
        .cfg_num_out_i  (cfg_num_out_i),
        .cfg_base_addr_i(cfg_base_addr_i),
        .cfg_bypass_i   (cfg_bypass_i),
        .bus            (bus),
`ifdef SFU_CTRL_STALL_CNT_EN
        .stall_cnt_o    (stall_cnt_o),
`endif
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    function automatic vec_t add_vec(vec_t a, vec_t b);
        vec_t r;
        for (int l = 0; l < Col; l++) r[l*PsumBw +: PsumBw] = a[l*PsumBw +: PsumBw] + b[l*PsumBw +: PsumBw];
        return r;
    endfunction

    function automatic vec_t relu_vec(vec_t a);
        vec_t r;
        for (int l = 0; l < Col; l++)
            r[l*PsumBw +: PsumBw] = a[l*PsumBw+PsumBw-1] ? '0 : a[l*PsumBw +: PsumBw];
        return r;
    endfunction

    function automatic vec_t splat(int v);
        vec_t r;
        for (int l = 0; l < Col; l++) r[l*PsumBw +: PsumBw] = v[PsumBw-1:0];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        int   v;
        for (int l = 0; l < Col; l++) begin
            v = int'($urandom_range(0, 200)) - 100;
            r[l*PsumBw +: PsumBw] = v[PsumBw-1:0];
        end
        return r;
    endfunction

    // SFU: accumulator reloads on the rising edge of acc, ReLU on the output.
    vec_t sfu_sum = '0;
    logic acc_prev = 1'b0;
    always @(posedge clk) begin
        acc_prev <= bus.sfu_acc_o;
        if (bus.sfu_acc_o) sfu_sum <= acc_prev ? add_vec(sfu_sum, bus.sfu_psum_o) : bus.sfu_psum_o;
    end
    assign bus.sfu_result_i = bus.sfu_bypass_o ? bus.sfu_psum_o : relu_vec(sfu_sum);

    int   n_checks = 0, n_pass = 0;
    vec_t fifo_q[$];
    int   hold_q[$];
    int   hold_left = 0, pops = 0, job_np = 1, job_no = 0, acc_hi = 0, stall_m = 0, done_cnt = 0;
    bit   job_byp = 0, job_act = 0, checking = 0, zero_due = 0;
    wr_t  exp_q[$];
    logic [AddrBw-1:0] wr_addr_log[$];
    vec_t wr_data_log[$];

    task automatic check(string name, vec_t act, vec_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive_fifo();
        if (fifo_q.size() > 0 && hold_left == 0) begin
            bus.fifo_valid_i = 1'b1;
            bus.fifo_data_i  = fifo_q[0];
        end else begin
            bus.fifo_valid_i = 1'b0;
            bus.fifo_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic tick();
        logic rd;
        @(negedge clk);
        rd = bus.fifo_rd_o;
        @(posedge clk);
        #1;
        if (rd === 1'b1) begin
            check("pop_nonempty", vec_t'(fifo_q.size() != 0), vec_t'(1));
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pops++;
            hold_left = (hold_q.size() != 0) ? hold_q.pop_front() : 0;
        end else if (bus.fifo_valid_i == 1'b0 && hold_left > 0) begin
            hold_left--;
        end
        drive_fifo();
    endtask

    // Per-cycle comparison against the job-level model.
    initial begin
        bit  exp_done;
        wr_t e;
        forever begin
            @(negedge clk);
            if (checking) begin
                exp_done = zero_due || (bus.mem_wr_o && exp_q.size() == 1);
                zero_due = 0;
                if (bus.mem_wr_o) begin
                    wr_addr_log.push_back(bus.mem_addr_o);
                    wr_data_log.push_back(bus.mem_data_o);
                    check("wr_expected", vec_t'(exp_q.size() != 0), vec_t'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", vec_t'(bus.mem_addr_o), vec_t'(e.addr));
                        check("wr_data", bus.mem_data_o, e.data);
                    end
                end
                if (done_o) done_cnt++;
                check("done", vec_t'(done_o), vec_t'(exp_done));
                check("psum_gate", bus.sfu_psum_o, bus.fifo_rd_o ? bus.fifo_data_i : '0);
                if (job_act && busy_o) begin
                    if (bus.sfu_acc_o) acc_hi++;
                    if (job_byp) begin
                        check("byp_acc_low", vec_t'(bus.sfu_acc_o), vec_t'(0));
                        if (pops < job_no) begin
                            check("byp_high", vec_t'(bus.sfu_bypass_o), vec_t'(1));
                            if (!bus.fifo_valid_i) stall_m++;
                        end
                    end else begin
                        check("acc_byp_low", vec_t'(bus.sfu_bypass_o), vec_t'(0));
                        if (pops % job_np != 0) begin
                            check("acc_mid_group", vec_t'(bus.sfu_acc_o), vec_t'(1));
                            if (!bus.fifo_valid_i) stall_m++;
                        end
                    end
                end
                if (start_i && !busy_o && reset && cfg_num_out_i == '0) zero_due = 1;
            end
        end
    end

    // fifo_q/hold_q must be loaded by the caller. Returns with the DUT idle again.
    task automatic run_job(int np, int no, int base, bit byp, int abort_pops, bit mid_start);
        vec_t v;
        wr_t  e;
        int   s;
        job_np = (np == 0) ? 1 : np;
        job_no = no;
        job_byp = byp;
        pops = 0; acc_hi = 0; stall_m = 0; done_cnt = 0;
        exp_q.delete(); wr_addr_log.delete(); wr_data_log.delete();
        for (int i = 0; i < no; i++) begin
            e.addr = AddrBw'(base + i);
            if (byp) e.data = fifo_q[i];
            else begin
                for (int l = 0; l < Col; l++) begin
                    s = 0;
                    for (int k = 0; k < job_np; k++) begin
                        v = fifo_q[i*job_np + k];
                        s += int'($signed(v[l*PsumBw +: PsumBw]));
                    end
                    if (s < 0) s = 0;
                    e.data[l*PsumBw +: PsumBw] = s[PsumBw-1:0];
                end
            end
            exp_q.push_back(e);
        end
        hold_left = (hold_q.size() != 0) ? hold_q.pop_front() : 0;
        cfg_num_psum_i = CntBw'(np); cfg_num_out_i = AddrBw'(no);
        cfg_base_addr_i = AddrBw'(base); cfg_bypass_i = byp;
        start_i = 1'b1; job_act = 1;
        drive_fifo();
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc < 2000 && busy_o; cyc++) begin
            if (abort_pops != 0 && pops == abort_pops) return;
            if (mid_start && cyc == 2) begin
                start_i = 1'b1; cfg_num_out_i = 3; cfg_bypass_i = ~byp; cfg_num_psum_i = 1;
            end else start_i = 1'b0;
            tick();
        end
        start_i = 1'b0;
        check("job_finished", vec_t'(busy_o), vec_t'(0));
        check("writes_left", vec_t'(exp_q.size()), vec_t'(0));
        check("done_count", vec_t'(done_cnt), vec_t'(1));
        check("acc_cycles", vec_t'(acc_hi), vec_t'(byp ? 0 : no * job_np + stall_m));
`ifdef SFU_CTRL_STALL_CNT_EN
        check("stall_cnt", vec_t'(stall_cnt_o), vec_t'(stall_m));
`endif
        job_act = 0;
        fifo_q.delete(); hold_q.delete(); hold_left = 0;
        drive_fifo();
        tick();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ctl"}, vec_t'({bus.fifo_rd_o, bus.sfu_acc_o, bus.sfu_bypass_o, bus.mem_wr_o,
                                     busy_o, done_o}), vec_t'(0));
        check({tag, "_psum"}, bus.sfu_psum_o, '0);
        check({tag, "_addr"}, vec_t'(bus.mem_addr_o), '0);
        check({tag, "_data"}, bus.mem_data_o, '0);
`ifdef SFU_CTRL_STALL_CNT_EN
        check({tag, "_stall"}, vec_t'(stall_cnt_o), '0);
`endif
    endtask

    initial begin
        int np, no;
        drive_fifo();
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        checking = 1;
        tick();

        // Two groups of three, FIFO always valid: 6 then relu(-11)=0.
        fifo_q = '{splat(1), splat(2), splat(3), splat(4), splat(5), splat(-20)};
        run_job(3, 2, 'h10, 0, 0, 0);
        check("t1_nwr", vec_t'(wr_addr_log.size()), vec_t'(2));
        check("t1_a0", vec_t'(wr_addr_log[0]), vec_t'('h10));
        check("t1_d0", wr_data_log[0], splat(6));
        check("t1_a1", vec_t'(wr_addr_log[1]), vec_t'('h11));
        check("t1_d1", wr_data_log[1], splat(0));

        // Three-cycle gap inside a group of two: 7 + 0 + 0 + 0 + 8.
        fifo_q = '{splat(7), splat(8)};
        hold_q = '{0, 3};
        run_job(2, 1, 'h20, 0, 0, 0);
        check("t2_d0", wr_data_log[0], splat(15));
        check("t2_acc", vec_t'(acc_hi), vec_t'(5));
`ifdef SFU_CTRL_STALL_CNT_EN
        check("t2_stall", vec_t'(stall_cnt_o), vec_t'(3));
`endif

        // Bypass across the address wrap, negatives kept.
        fifo_q = '{splat(-5), splat(7), splat(0), splat(-1)};
        run_job(0, 4, 'h7FE, 1, 0, 0);
        check("t3_a2", vec_t'(wr_addr_log[2]), vec_t'(0));
        check("t3_a3", vec_t'(wr_addr_log[3]), vec_t'(1));
        check("t3_d0", wr_data_log[0], splat(-5));
        check("t3_d3", wr_data_log[3], splat(-1));

        // Single-psum groups.
        fifo_q = '{splat(-3)};
        run_job(1, 1, 'h40, 0, 0, 0);
        check("t4_acc_a", vec_t'(acc_hi), vec_t'(1));
        check("t4_d_a", wr_data_log[0], splat(0));
        fifo_q = '{splat(9)};
        run_job(1, 1, 'h41, 0, 0, 0);
        check("t4_acc_b", vec_t'(acc_hi), vec_t'(1));
        check("t4_d_b", wr_data_log[0], splat(9));

        // Reset in the middle of a group (two psums already accumulated).
        for (int i = 0; i < 4; i++) fifo_q.push_back(rand_vec());
        run_job(4, 1, 'h50, 0, 2, 0);
        checking = 0; job_act = 0;
        reset = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b1;
        fifo_q.delete(); hold_q.delete(); hold_left = 0;
        drive_fifo();
        tick();
        check("midrst_nowr", vec_t'(bus.mem_wr_o), vec_t'(0));
        check("midrst_idle", vec_t'(busy_o), vec_t'(0));
        checking = 1;
        for (int i = 0; i < 6; i++) fifo_q.push_back(rand_vec());
        run_job(3, 2, 'h60, 0, 0, 0);

        // Zero outputs: done only, no writes.
        run_job(2, 0, 'h70, 0, 0, 0);
        check("t6_nwr", vec_t'(wr_addr_log.size()), vec_t'(0));

        // Start pulses while busy must not spawn a job.
        for (int i = 0; i < 6; i++) fifo_q.push_back(rand_vec());
        run_job(2, 3, 'h80, 0, 0, 1);
        for (int i = 0; i < 3; i++) fifo_q.push_back(rand_vec());
        run_job(0, 3, 'h90, 1, 0, 1);

        // Random jobs with random FIFO bubbles.
        for (int j = 0; j < 10; j++) begin
            np = $urandom_range(0, 4);
            no = $urandom_range(1, 5);
            cfg_bypass_i = $urandom_range(0, 1);
            for (int i = 0; i < (cfg_bypass_i ? no : no * (np == 0 ? 1 : np)); i++) begin
                fifo_q.push_back(rand_vec());
                hold_q.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_job(np, no, $urandom_range(0, 2047), cfg_bypass_i, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
